// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative shift-add multiplier for the ALU HI/LO path.
// One partial-product step per clock. The unit supports signed (MULT) and
// unsigned (MULTU) modes, selected by the function code on Signal.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high; clears all state including dataOut
//   start    request pulse; accepted in IDLE with a MULT/MULTU code only
//   dataA    multiplicand
//   dataB    multiplier
//   Signal   function code
//   busy     operation in progress
//   done     one-cycle strobe; dataOut shows the new product in the same cycle
//   dataOut  2*WIDTH-bit product register, held until the next completion
//   hi, lo   upper and lower halves of dataOut
module seq_mul_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter logic [5:0]  FUNCT_MULT  = 6'b011000,
    parameter logic [5:0]  FUNCT_MULTU = 6'b011001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int unsigned PW = 2 * WIDTH;          // product width
    localparam int unsigned MW = WIDTH + 1;          // operand magnitude width
    localparam int unsigned CW = $clog2(WIDTH + 1);  // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state;
    logic [PW-1:0]  acc;
    logic [PW-1:0]  mcand;
    logic [MW-1:0]  mplier;
    logic [CW-1:0]  count;
    logic           neg;

    logic           is_mult;
    logic           is_multu;
    logic [MW-1:0]  a_ext;
    logic [MW-1:0]  b_ext;
    logic [MW-1:0]  a_mag;
    logic [MW-1:0]  b_mag;

    assign is_mult  = (Signal == FUNCT_MULT);
    assign is_multu = (Signal == FUNCT_MULTU);

    // Operands are widened by one bit so that |-2^(WIDTH-1)| is representable.
    // The extension is a sign extension in signed mode and a zero extension
    // in unsigned mode.
    assign a_ext = {dataA[WIDTH-1] & is_mult, dataA};
    assign b_ext = {dataB[WIDTH-1] & is_mult, dataB};
    assign a_mag = (is_mult && dataA[WIDTH-1]) ? (~a_ext + MW'(1)) : a_ext;
    assign b_mag = (is_mult && dataB[WIDTH-1]) ? (~b_ext + MW'(1)) : b_ext;

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dataOut <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (is_mult || is_multu)) begin
                        mcand  <= PW'(a_mag);
                        mplier <= b_mag;
                        neg    <= is_mult & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                        acc    <= '0;
                        count  <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    // A zero magnitude negates to zero, so there is no -0 case.
                    dataOut <= neg ? (~acc + PW'(1)) : acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign hi = dataOut[PW-1:WIDTH];
    assign lo = dataOut[WIDTH-1:0];

endmodule

// File: tb/tb_seq_mul_unit.sv
// Testbench for seq_mul_unit. It drives a 32-bit instance and an 8-bit
// instance. Expected products and completion cycles go into per-instance
// queues when a start is driven, and they are popped when done is seen.
module tb_seq_mul_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;

    logic        clk = 1'b0;
    logic        reset;

    logic        start32;
    logic [31:0] a32, b32;
    logic [5:0]  f32;
    logic        busy32, done32;
    logic [63:0] data32;
    logic [31:0] hi32, lo32;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [5:0]  f8;
    logic        busy8, done8;
    logic [15:0] data8;
    logic [7:0]  hi8, lo8;

    always #5 clk = ~clk;

    seq_mul_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .dataA(a32), .dataB(b32),
        .Signal(f32), .busy(busy32), .done(done32), .dataOut(data32),
        .hi(hi32), .lo(lo32)
    );

    seq_mul_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .dataA(a8), .dataB(b8),
        .Signal(f8), .busy(busy8), .done(done8), .dataOut(data8),
        .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [63:0] data;
        int          due;
    } sb_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        logic [63:0] exp;
    } vec_t;

    sb_t         q32[$];
    sb_t         q8[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [63:0] last32 = '0;
    logic [63:0] last8 = '0;
    int          done32_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next negedge and check any completions that are due.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        cyc++;
        if (done32 === 1'b1) begin
            done32_seen++;
            if (q32.size() == 0) begin
                chk("done32_unexpected", 64'(done32), 64'd0);
            end else begin
                e = q32.pop_front();
                last32 = e.data;
                chk("data32", data32, e.data);
                chk("hi32", 64'(hi32), 64'(e.data[63:32]));
                chk("lo32", 64'(lo32), 64'(e.data[31:0]));
                chk("lat32", 64'(cyc), 64'(e.due));
                chk("busy32_at_done", 64'(busy32), 64'd0);
            end
        end else if (q32.size() > 0 && cyc > q32[0].due) begin
            e = q32.pop_front();
            chk("timeout32", 64'(cyc), 64'(e.due));
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 64'(done8), 64'd0);
            end else begin
                e = q8.pop_front();
                last8 = e.data;
                chk("data8", 64'(data8), e.data);
                chk("hilo8", 64'({hi8, lo8}), e.data);
                chk("lat8", 64'(cyc), 64'(e.due));
            end
        end else if (q8.size() > 0 && cyc > q8[0].due) begin
            e = q8.pop_front();
            chk("timeout8", 64'(cyc), 64'(e.due));
        end
    endtask

    // Drive a one-cycle start pulse. The start is sampled on the next
    // posedge, and done becomes visible WIDTH+1 posedges after that.
    task automatic launch(input bit w8, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input bit expect_done, input logic [63:0] exp);
        sb_t e;
        if (w8) begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; f8 = f;
            e.due = cyc + 8 + 2;
        end else begin
            start32 = 1'b1; a32 = a; b32 = b; f32 = f;
            e.due = cyc + 32 + 2;
        end
        e.data = exp;
        if (expect_done) begin
            if (w8) q8.push_back(e);
            else    q32.push_back(e);
        end
        tick();
        start8 = 1'b0;
        start32 = 1'b0;
        // Operands need not be held after acceptance
        a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) tick();
        if (q32.size() != 0 || q8.size() != 0) begin
            chk("drain", 64'(q32.size() + q8.size()), 64'd0);
            q32.delete();
            q8.delete();
        end
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint p;
        logic [63:0] u;
        if (sgn) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return 64'(p);
        end
        u = {32'd0, a} * {32'd0, b};
        return u;
    endfunction

    function automatic logic [63:0] ref8(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        longint p;
        logic [15:0] u;
        if (sgn) begin
            p = longint'($signed(a)) * longint'($signed(b));
            u = p[15:0];
        end else begin
            u = {8'd0, a} * {8'd0, b};
        end
        return {48'd0, u};
    endfunction

    vec_t vt[8];

    initial begin
        int bc;
        int dc;
        logic [31:0] ra, rb;
        bit rs;

        vt[0] = '{32'd7,          32'd6,          F_MULTU, 64'd42};
        vt[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   F_MULTU, 64'hFFFFFFFE_00000001};
        vt[2] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   F_MULT,  64'd1};
        vt[3] = '{32'hFFFFFFFD,   32'd5,          F_MULT,  64'hFFFFFFFF_FFFFFFF1};
        vt[4] = '{32'h80000000,   32'h80000000,   F_MULT,  64'h40000000_00000000};
        vt[5] = '{32'd0,          32'hFFFFFFF7,   F_MULT,  64'd0};
        vt[6] = '{32'h80000000,   32'd2,          F_MULTU, 64'h00000001_00000000};
        vt[7] = '{32'h7FFFFFFF,   32'h80000000,   F_MULT,  64'hC0000000_80000000};

        reset = 1'b1;
        start32 = 1'b0; a32 = '0; b32 = '0; f32 = '0;
        start8 = 1'b0;  a8 = '0;  b8 = '0;  f8 = '0;
        repeat (3) tick();
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_done32", 64'(done32), 64'd0);
        chk("rst_data32", data32, 64'd0);
        chk("rst_busy8",  64'(busy8), 64'd0);
        chk("rst_data8",  64'(data8), 64'd0);
        reset = 1'b0;
        tick();

        // 7*6: busy must be high for exactly 33 sampled cycles and done must pulse once
        launch(1'b0, 32'd7, 32'd6, F_MULTU, 1'b1, 64'd42);
        bc = (busy32 === 1'b1) ? 1 : 0;
        done32_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy32 === 1'b1) bc++;
        end
        chk("busy32_len", 64'(bc), 64'd33);
        chk("done32_pulses", 64'(done32_seen), 64'd1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            launch(1'b0, vt[i].a, vt[i].b, vt[i].f, 1'b1, vt[i].exp);
            wait_idle();
        end

        // An illegal function code is ignored
        launch(1'b0, 32'd3, 32'd3, 6'b100000, 1'b0, 64'd0);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy32 === 1'b1 || done32 === 1'b1) bc++;
            tick();
        end
        chk("illegal_activity", 64'(bc), 64'd0);
        chk("illegal_hold", data32, last32);

        // A start pulsed mid-RUN is ignored
        launch(1'b0, 32'h1234, 32'h5678, F_MULTU, 1'b1, 64'h0626_0060);
        repeat (10) tick();
        launch(1'b0, 32'd99, 32'd99, F_MULT, 1'b0, 64'd0);
        wait_idle();
        done32_seen = 0;
        repeat (40) tick();
        chk("midrun_no_second_done", 64'(done32_seen), 64'd0);

        // A start in the done cycle is accepted back-to-back
        launch(1'b0, 32'd1000, 32'd1000, F_MULTU, 1'b1, 64'd1000000);
        for (int i = 0; i < 60 && done32 !== 1'b1; i++) tick();
        chk("b2b_done_seen", 64'(done32), 64'd1);
        launch(1'b0, 32'hFFFFFFFE, 32'd3, F_MULT, 1'b1, 64'hFFFFFFFF_FFFFFFFA);
        wait_idle();

        // A reset mid-RUN aborts the operation and clears the product
        launch(1'b0, 32'd3, 32'd3, F_MULTU, 1'b1, 64'd9);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q32.delete();
        chk("abort_busy", 64'(busy32), 64'd0);
        chk("abort_done", 64'(done32), 64'd0);
        chk("abort_data", data32, 64'd0);
        chk("abort_hilo", 64'({hi32, lo32}), 64'd0);
        last32 = '0;
        last8 = '0;
        done32_seen = 0;
        repeat (45) tick();
        chk("abort_no_done", 64'(done32_seen), 64'd0);
        launch(1'b0, 32'd12, 32'hFFFFFFFF, F_MULT, 1'b1, 64'hFFFFFFFF_FFFFFFF4);
        wait_idle();

        // 8-bit instance: signed extreme, then a random sweep
        launch(1'b1, 32'h80, 32'h7F, F_MULT, 1'b1, 64'h0000_0000_0000_C080);
        wait_idle();
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            launch(1'b1, ra, rb, rs ? F_MULT : F_MULTU, 1'b1, ref8(ra[7:0], rb[7:0], rs));
            wait_idle();
        end

        // A short random sweep on the 32-bit instance
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            launch(1'b0, ra, rb, rs ? F_MULT : F_MULTU, 1'b1, ref32(ra, rb, rs));
            wait_idle();
        end

        dc = 0;
        repeat (5) tick();
        chk("final_hold32", data32, last32);
        chk("final_hold8", 64'(data8), last8);
        chk("final_idle", 64'({busy32, busy8}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
